// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Magnitude datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   shifted, diff, sum;

  // Multiply: sh holds the multiplier, product forms in {acc, sh}.
  // Divide: sh holds dividend bits shifting out and quotient bits shifting in; acc is the remainder.
  always_comb begin
    acc_d   = acc_q;
    sh_d    = sh_q;
    b_d     = b_q;
    shifted = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    sum     = acc_q + (sh_q[0] ? {1'b0, b_q} : '0);
    if (load) begin
      acc_d = '0;
      sh_d  = a_mag;
      b_d   = b_mag;
    end else if (step) begin
      if (is_div) begin
        if (!diff[WIDTH]) begin
          acc_d = diff;
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted;
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {1'b0, sum[WIDTH:1]};
        sh_d  = {sum[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    sh_q  <= sh_d;
    b_q   <= b_d;
  end

  assign res_hi = acc_q[WIDTH-1:0];
  assign res_lo = sh_q;

endmodule

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU engine owning HI/LO; also handles MTHI/MTLO.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// CALC  | WIDTH magnitude iterations
// FIX   | sign correction and HI/LO write
// DONE  | done pulse; accepts a new start like IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, neg_q_q, neg_r_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             accept, is_md, signed_op, a_neg, b_neg, b_zero, load, step;
  logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign is_md     = !op[2];
  assign signed_op = !op[0];
  assign a_neg     = signed_op && A[WIDTH-1];
  assign b_neg     = signed_op && B[WIDTH-1];
  assign b_zero    = (B == '0);
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
  assign load      = accept && is_md && !(op[1] && b_zero);
  assign step      = (state_q == CALC);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .load   (load),
    .step   (step),
    .is_div (is_div_q),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign prod_fix = neg_q_q ? -{res_hi, res_lo} : {res_hi, res_lo};
  assign quot_fix = neg_q_q ? -res_lo : res_lo;
  assign rem_fix  = neg_r_q ? -res_hi : res_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (accept) begin
            case (op)
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                if (op[1] && b_zero) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  dbz_q   <= 1'b1;
                end else begin
                  state_q  <= CALC;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  is_div_q <= op[1];
                  neg_q_q  <= a_neg ^ b_neg;
                  neg_r_q  <= a_neg;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model checked every cycle.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results from plain 64-bit arithmetic, timing from the issue rules.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = ua * ub;
      OP_DIV:   r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  r = {32'(ua % ub), 32'(ua / ub)};
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0, m_dbz = 1'b0, m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [63:0] r;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_dbz = 1'b0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (start) begin
        if (op == OP_MTHI) m_hi = A;
        else if (op == OP_MTLO) m_lo = A;
        else if ((op == OP_DIV || op == OP_DIVU) && B == 0) begin
          m_done = 1'b1; m_dbz = 1'b1;
        end else if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
          r = ref_result(op, A, B);
          {p_hi, p_lo} = r;
          m_rem = W + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_busy", 32'(busy), 32'(m_rem > 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    while (!done && cycles < max) begin
      step();
      cycles++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  typedef struct { logic [2:0] o; logic [31:0] a; logic [31:0] b; logic [31:0] ehi; logic [31:0] elo; } vec_t;
  vec_t vecs[6];

  initial begin
    int cyc, dones;
    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b);
      wait_done(60, cyc);
      chk($sformatf("lat%0d", i), 32'(cyc), 32'd33);
      chk($sformatf("hi%0d", i), hi, vecs[i].ehi);
      chk($sformatf("lo%0d", i), lo, vecs[i].elo);
      chk($sformatf("busy_at_done%0d", i), 32'(busy), 32'd0);
      step();
    end

    // Extra operands covered by the model only.
    issue(OP_MULT, 32'h12345678, 32'h9ABCDEF0); wait_done(60, cyc); step();
    issue(OP_DIV, 32'd1000, 32'hFFFFFFFD); wait_done(60, cyc); step();
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd1); wait_done(60, cyc); step();

    issue(OP_MTHI, 32'hAA, 32'd0);
    chk("mthi", hi, 32'hAA);
    issue(OP_MTLO, 32'hBB, 32'd0);
    chk("mtlo", lo, 32'hBB);
    issue(3'b110, 32'h1234, 32'h1);
    chk("noop_hi", hi, 32'hAA);
    chk("noop_lo", lo, 32'hBB);

    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(5, cyc);
    chk("dbz_lat", 32'(cyc), 32'd0);
    chk("dbz_flag", 32'(div_by_zero), 32'd1);
    chk("dbz_hi", hi, 32'hAA);
    chk("dbz_lo", lo, 32'hBB);
    step();
    chk("dbz_pulse_end", 32'(div_by_zero), 32'd0);

    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (3) step();
    issue(OP_MTLO, 32'h1234, 32'd0);
    chk("mtlo_ignored", lo, 32'hBB);
    wait_done(60, cyc);
    issue(OP_MTHI, 32'h55, 32'd0);
    chk("b2b_lo", lo, 32'd12);
    chk("b2b_hi", hi, 32'h55);

    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (8) step();
    reset = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (50) begin
      step();
      if (done) dones++;
    end
    chk("no_done_after_rst", 32'(dones), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
